m4_coef_ctrl: RTL and testbench

Configuration controller for the M4 3x3 colour-matrix multiplier. Takes host register writes into a shadow bank of nine 13-bit coefficients plus an enable bit, and commits the whole bank atomically to the active CF0D..CF8D / M4_ON outputs on the frame-boundary pulse OVP. A coefficient set therefore never changes mid-frame. Sits between the host register bus and the matrix multiplier; its outputs drive the multiplier's coefficient and enable inputs directly.

---
 rtl/m4_coef_ctrl.sv | 105 ++++++++++
 tb/tb_m4_coef_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m4_coef_ctrl.sv
// Coefficient/enable controller for the M4 colour-matrix multiplier: host writes land in a
// shadow bank, which is committed atomically to the active outputs on a frame-boundary pulse.
module m4_coef_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [12:0] wr_data,
    output logic        wr_rdy,
    input  logic        ovp,
    input  logic        cancel,
    output logic [12:0] cf0d,
    output logic [12:0] cf1d,
    output logic [12:0] cf2d,
    output logic [12:0] cf3d,
    output logic [12:0] cf4d,
    output logic [12:0] cf5d,
    output logic [12:0] cf6d,
    output logic [12:0] cf7d,
    output logic [12:0] cf8d,
    output logic        m4_on,
    output logic        pending,
    output logic        upd_done,
    output logic        wr_err
);

    typedef enum logic [1:0] {IDLE, ARMED, APPLY} state_t;

    state_t      state, state_nxt;
    logic [12:0] sh  [9];
    logic [12:0] act [9];
    logic        sh_on;
    logic        wr_acc;

    // Identity matrix: 1.0 on the diagonal (indices 0, 4, 8), zero elsewhere.
    function automatic logic [12:0] reset_coef(input int idx);
        return (idx % 4 == 0) ? 13'h1000 : 13'h0000;
    endfunction

    assign wr_acc  = wr_en && (state == IDLE);
    assign wr_rdy  = (state == IDLE);
    assign pending = (state == ARMED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (wr_acc && wr_addr == 4'd9 && wr_data[1]) state_nxt = ARMED;
            ARMED:   if (ovp)         state_nxt = APPLY;
                     else if (cancel) state_nxt = IDLE;
            APPLY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: both banks are small register files with architectural reset values, so they are
    // reset explicitly in the flop loop rather than left to power-up contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) sh[i] <= reset_coef(i);
            sh_on <= 1'b0;
        end else if (wr_acc) begin
            for (int i = 0; i < 9; i++)
                if (wr_addr == 4'(i)) sh[i] <= wr_data;
            if (wr_addr == 4'd9) sh_on <= wr_data[0];
        end
    end

    // Active bank only moves on the edge that leaves APPLY, keeping a frame's set intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) act[i] <= reset_coef(i);
            m4_on <= 1'b0;
        end else if (state == APPLY) begin
            for (int i = 0; i < 9; i++) act[i] <= sh[i];
            m4_on <= sh_on;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_done <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            upd_done <= (state == APPLY);
            wr_err   <= wr_acc && (wr_addr >= 4'd10);
        end
    end

    assign cf0d = act[0];
    assign cf1d = act[1];
    assign cf2d = act[2];
    assign cf3d = act[3];
    assign cf4d = act[4];
    assign cf5d = act[5];
    assign cf6d = act[6];
    assign cf7d = act[7];
    assign cf8d = act[8];

endmodule

// File: tb/tb_m4_coef_ctrl.sv
// Testbench for m4_coef_ctrl: directed scenarios plus random traffic, all checked against a
// transaction-level model of the shadow/active banks.
module tb_m4_coef_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [12:0] wr_data = '0;
    logic        ovp = 1'b0;
    logic        cancel = 1'b0;
    logic        wr_rdy, m4_on, pending, upd_done, wr_err;
    logic [12:0] cf0d, cf1d, cf2d, cf3d, cf4d, cf5d, cf6d, cf7d, cf8d;

    int total = 0;
    int bad   = 0;

    localparam logic [121:0] RST_VEC = {13'h1000, 13'h0, 13'h0, 13'h0, 13'h1000, 13'h0, 13'h0,
                                        13'h0, 13'h1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Model: shadow and active banks, plus whether a commit is armed or being applied.
    logic [12:0] m_sh  [0:8];
    logic [12:0] m_act [0:8];
    logic        m_sh_on, m_on, m_armed, m_applying, m_upd, m_err;

    m4_coef_ctrl dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_rdy(wr_rdy), .ovp(ovp), .cancel(cancel),
        .cf0d(cf0d), .cf1d(cf1d), .cf2d(cf2d), .cf3d(cf3d), .cf4d(cf4d),
        .cf5d(cf5d), .cf6d(cf6d), .cf7d(cf7d), .cf8d(cf8d),
        .m4_on(m4_on), .pending(pending), .upd_done(upd_done), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [121:0] obs_vec();
        return {cf0d, cf1d, cf2d, cf3d, cf4d, cf5d, cf6d, cf7d, cf8d,
                m4_on, wr_rdy, pending, upd_done, wr_err};
    endfunction

    function automatic logic [121:0] exp_vec();
        return {m_act[0], m_act[1], m_act[2], m_act[3], m_act[4], m_act[5], m_act[6], m_act[7],
                m_act[8], m_on, !(m_armed || m_applying), m_armed, m_upd, m_err};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) begin
            m_sh[i]  = (i == 0 || i == 4 || i == 8) ? 13'h1000 : 13'h0;
            m_act[i] = m_sh[i];
        end
        m_sh_on = 0; m_on = 0; m_armed = 0; m_applying = 0; m_upd = 0; m_err = 0;
    endtask

    // Advance the model by one clock using the inputs currently presented to the DUT.
    task automatic model_step();
        m_upd = m_applying;
        m_err = 1'b0;
        if (m_applying) begin
            for (int i = 0; i < 9; i++) m_act[i] = m_sh[i];
            m_on = m_sh_on;
            m_applying = 1'b0;
        end else if (m_armed) begin
            if (ovp) begin
                m_armed = 1'b0;
                m_applying = 1'b1;
            end else if (cancel) begin
                m_armed = 1'b0;
            end
        end else if (wr_en) begin
            if (wr_addr < 4'd9) m_sh[wr_addr] = wr_data;
            else if (wr_addr == 4'd9) begin
                m_sh_on = wr_data[0];
                m_armed = wr_data[1];
            end else m_err = 1'b1;
        end
    endtask

    // Present inputs for one cycle, step the model, and land 1 time unit after the edge.
    task automatic cyc(input logic we, input logic [3:0] a, input logic [12:0] d,
                       input logic o, input logic c);
        wr_en = we; wr_addr = a; wr_data = d; ovp = o; cancel = c;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs_vec() !== RST_VEC) begin
            bad++; $display("FAIL reset_state: got %h want %h", obs_vec(), RST_VEC);
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0, 0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL reset_idle[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        total++;
        if (obs_vec() !== RST_VEC) begin
            bad++; $display("FAIL reset_hold: got %h want %h", obs_vec(), RST_VEC);
        end
    endtask

    task automatic test_commit();
        int ups = 0;
        cyc(1, 4'd1, 13'h1F00, 0, 0);
        cyc(1, 4'd4, 13'h0800, 0, 0);
        cyc(1, 4'd9, 13'h0003, 0, 0);
        total++;
        if ({pending, wr_rdy} !== 2'b10) begin
            bad++; $display("FAIL commit_arm: got pending/rdy %b want 10", {pending, wr_rdy});
        end
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0);
            ups += int'(upd_done);
            total++;
            if (obs_vec() !== exp_vec() || cf1d !== 13'h0 || cf4d !== 13'h1000) begin
                bad++; $display("FAIL commit_wait[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        cyc(0, 0, 0, 1, 0);
        ups += int'(upd_done);
        total++;
        if ({cf1d, cf4d, m4_on, upd_done} !== {13'h0, 13'h1000, 1'b0, 1'b0}) begin
            bad++; $display("FAIL commit_apply: got cf1d=%h cf4d=%h on=%b upd=%b want 0000 1000 0 0",
                            cf1d, cf4d, m4_on, upd_done);
        end
        cyc(0, 0, 0, 0, 0);
        ups += int'(upd_done);
        total++;
        if ({cf1d, cf4d, m4_on, upd_done, pending, wr_rdy} !== {13'h1F00, 13'h0800, 4'b1101}) begin
            bad++; $display("FAIL commit_done: got cf1d=%h cf4d=%h flags=%b want 1f00 0800 1101",
                            cf1d, cf4d, {m4_on, upd_done, pending, wr_rdy});
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0);
            ups += int'(upd_done);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL commit_after[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        total++;
        if (ups != 1) begin
            bad++; $display("FAIL commit_upd_count: got %0d want 1", ups);
        end
    endtask

    task automatic test_cancel();
        cyc(1, 4'd5, 13'h0AAA, 0, 0);
        cyc(1, 4'd9, 13'h0002, 0, 0);
        cyc(0, 0, 0, 0, 1);
        total++;
        if ({pending, wr_rdy, m4_on} !== 3'b011 || cf5d !== 13'h0 || cf1d !== 13'h1F00) begin
            bad++; $display("FAIL cancel_drop: got flags=%b cf5d=%h cf1d=%h want 011 0000 1f00",
                            {pending, wr_rdy, m4_on}, cf5d, cf1d);
        end
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0);
            total++;
            if (obs_vec() !== exp_vec() || upd_done !== 1'b0 || cf5d !== 13'h0) begin
                bad++; $display("FAIL cancel_no_commit[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        cyc(1, 4'd9, 13'h0003, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        total++;
        if ({cf5d, m4_on, upd_done} !== {13'h0AAA, 2'b11}) begin
            bad++; $display("FAIL cancel_rearm: got cf5d=%h on=%b upd=%b want 0aaa 1 1",
                            cf5d, m4_on, upd_done);
        end
    endtask

    task automatic test_ovp_cancel();
        cyc(1, 4'd3, 13'h1ABC, 0, 0);
        cyc(1, 4'd9, 13'h0002, 0, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0);
        total++;
        if ({cf3d, m4_on, upd_done} !== {13'h1ABC, 2'b01} || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL ovp_beats_cancel: got cf3d=%h on=%b upd=%b want 1abc 0 1",
                            cf3d, m4_on, upd_done);
        end
    endtask

    task automatic test_stall();
        cyc(1, 4'd9, 13'h0003, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 4'd2, 13'h0123, 0, 0);
            total++;
            if (wr_rdy !== 1'b0 || obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL stall_hold[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        cyc(1, 4'd2, 13'h0123, 1, 0);
        total++;
        if (wr_rdy !== 1'b0) begin
            bad++; $display("FAIL stall_apply_rdy: got %b want 0", wr_rdy);
        end
        cyc(1, 4'd2, 13'h0123, 0, 0);
        total++;
        if ({wr_rdy, upd_done} !== 2'b11 || cf2d !== 13'h0) begin
            bad++; $display("FAIL stall_release: got rdy/upd=%b cf2d=%h want 11 0000",
                            {wr_rdy, upd_done}, cf2d);
        end
        cyc(1, 4'd2, 13'h0123, 0, 0);
        cyc(0, 0, 0, 0, 0);
        total++;
        if (cf2d !== 13'h0 || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL stall_not_active: got cf2d=%h want 0000", cf2d);
        end
        cyc(1, 4'd9, 13'h0003, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        total++;
        if (cf2d !== 13'h0123 || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL stall_landed: got cf2d=%h want 0123", cf2d);
        end
    endtask

    task automatic test_invalid();
        cyc(1, 4'd12, 13'($urandom), 0, 0);
        total++;
        if (wr_err !== 1'b1 || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL invalid_err: got %h want %h", obs_vec(), exp_vec());
        end
        cyc(0, 0, 0, 0, 0);
        total++;
        if (wr_err !== 1'b0) begin
            bad++; $display("FAIL invalid_pulse_len: got %b want 0", wr_err);
        end
        cyc(1, 4'd9, 13'h0003, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL invalid_no_store: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_armed();
        cyc(1, 4'd6, 13'h0555, 0, 0);
        cyc(1, 4'd9, 13'h0003, 0, 0);
        cyc(0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs_vec() !== RST_VEC) begin
            bad++; $display("FAIL reset_async: got %h want %h", obs_vec(), RST_VEC);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0);
            total++;
            if (obs_vec() !== RST_VEC || obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL reset_lost_commit[%0d]: got %h want %h", i, obs_vec(), RST_VEC);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [3:0] a;
            a = ($urandom % 4 == 0) ? 4'd9 : 4'($urandom % 16);
            cyc(1'($urandom % 2), a, 13'($urandom), ($urandom % 6 == 0), ($urandom % 6 == 0));
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_commit();
        test_cancel();
        test_ovp_cancel();
        test_stall();
        test_invalid();
        test_reset_armed();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
